// File: rtl/ff_sweep_sequencer.sv
// ff_sweep_sequencer: native-bus master that drives a phase sweep on the
// flip-flop metastability test core. It loads the init value once. It then
// runs one probability test per sweep point and emits one result record per
// point. Between points it issues `stride` phase-shift writes.
//
// Optional feature: define SWEEP_TIMEOUT_EN to bound every bus wait to
// TIMEOUT_CYCLES. On expiry err is set and the sweep finishes. Without the
// macro, waits are unbounded and err is tied low.
//
// Ports:
//   NATIVE_CLK, rst_n       clock (shared with core), async active-low reset
//   cfg_start               one-cycle start pulse (ignored while busy)
//   cfg_steps/stride/dir    sweep shape, sampled at start
//   cfg_init                init value written to core address 1
//   abort                   level; stops the sweep after the current record
//   busy, done, err         status (done is a one-cycle pulse, err is sticky)
//   M_EN/M_WR/M_ADDR/M_WDATA/M_RDATA/M_READY   native bus master
//   res_valid/res_ready/res_step/res_prob      result record stream
module ff_sweep_sequencer #(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STEP_W         = 16,
  parameter int unsigned STRIDE_W       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                NATIVE_CLK,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [STEP_W-1:0]   cfg_steps,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic                cfg_dir,
  input  logic                cfg_init,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                M_EN,
  output logic                M_WR,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W-1:0]   M_WDATA,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic                M_READY,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [STEP_W-1:0]   res_step,
  output logic [DATA_W-1:0]   res_prob
);

  typedef enum logic [3:0] {
    IDLE, LOAD, LOAD_WAIT, TEST, TEST_WAIT, PUSH, SHIFT, SHIFT_WAIT, FINISH
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                m_en_q, m_en_d;
  logic                m_wr_q, m_wr_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                res_valid_q, res_valid_d;
  logic [STEP_W-1:0]   res_step_q, res_step_d;
  logic [DATA_W-1:0]   res_prob_q, res_prob_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic [STRIDE_W-1:0] shift_cnt_q, shift_cnt_d;
  logic                rdy_c;

`ifdef SWEEP_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Ready counts only after the strobe cycle; the core's ready is registered.
  assign rdy_c = M_READY && !m_en_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    m_en_d      = 1'b0;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    res_valid_d = res_valid_q;
    res_step_d  = res_step_q;
    res_prob_d  = res_prob_q;
    steps_d     = steps_q;
    stride_d    = stride_q;
    dir_d       = dir_q;
    step_idx_d  = step_idx_q;
    shift_cnt_d = shift_cnt_q;
`ifdef SWEEP_TIMEOUT_EN
    err_d       = err_q;
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          steps_d    = cfg_steps;
          stride_d   = cfg_stride;
          dir_d      = cfg_dir;
          step_idx_d = '0;
`ifdef SWEEP_TIMEOUT_EN
          err_d      = 1'b0;
`endif
          // A start under abort, or with no points, finishes without bus activity.
          state_d = (cfg_steps == '0 || abort) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        m_en_d    = 1'b1;
        m_wr_d    = 1'b1;
        m_addr_d  = ADDR_W'(1);
        m_wdata_d = DATA_W'(cfg_init);
        state_d   = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (rdy_c) state_d = TEST;
      end
      TEST: begin
        m_en_d   = 1'b1;
        m_wr_d   = 1'b0;
        m_addr_d = ADDR_W'(2);
        state_d  = TEST_WAIT;
      end
      TEST_WAIT: begin
        if (rdy_c) begin
          res_prob_d  = M_RDATA;
          res_step_d  = step_idx_q;
          res_valid_d = 1'b1;
          state_d     = PUSH;
        end
      end
      PUSH: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (step_idx_q == steps_q - STEP_W'(1) || abort) begin
            state_d = FINISH;
          end else begin
            step_idx_d  = step_idx_q + STEP_W'(1);
            shift_cnt_d = stride_q;
            state_d     = (stride_q != '0) ? SHIFT : TEST;
          end
        end
      end
      SHIFT: begin
        m_en_d    = 1'b1;
        m_wr_d    = 1'b1;
        m_addr_d  = ADDR_W'(0);
        m_wdata_d = DATA_W'(dir_q);
        state_d   = SHIFT_WAIT;
      end
      SHIFT_WAIT: begin
        // Returning through SHIFT guarantees an idle cycle between shift strobes.
        if (rdy_c) begin
          shift_cnt_d = shift_cnt_q - STRIDE_W'(1);
          state_d     = (shift_cnt_q == STRIDE_W'(1)) ? TEST : SHIFT;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SWEEP_TIMEOUT_EN
    // Wait-cycle counter: the strobe cycle counts as the first waited cycle.
    if (m_en_d) begin
      tmo_cnt_d = TMO_W'(1);
    end else if ((state_q == LOAD_WAIT || state_q == TEST_WAIT ||
                  state_q == SHIFT_WAIT) && !rdy_c) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = FINISH;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      m_en_q      <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      res_valid_q <= 1'b0;
      res_step_q  <= '0;
      res_prob_q  <= '0;
      steps_q     <= '0;
      stride_q    <= '0;
      dir_q       <= 1'b0;
      step_idx_q  <= '0;
      shift_cnt_q <= '0;
`ifdef SWEEP_TIMEOUT_EN
      err_q       <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      m_en_q      <= m_en_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      res_valid_q <= res_valid_d;
      res_step_q  <= res_step_d;
      res_prob_q  <= res_prob_d;
      steps_q     <= steps_d;
      stride_q    <= stride_d;
      dir_q       <= dir_d;
      step_idx_q  <= step_idx_d;
      shift_cnt_q <= shift_cnt_d;
`ifdef SWEEP_TIMEOUT_EN
      err_q       <= err_d;
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

`ifdef SWEEP_TIMEOUT_EN
  assign err = err_q;
`else
  // Waits are unbounded in this build; the limit parameter has no effect.
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
  assign err = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign M_EN      = m_en_q;
  assign M_WR      = m_wr_q;
  assign M_ADDR    = m_addr_q;
  assign M_WDATA   = m_wdata_q;
  assign res_valid = res_valid_q;
  assign res_step  = res_step_q;
  assign res_prob  = res_prob_q;

endmodule

// File: tb/tb_ff_sweep_sequencer.sv
// Testbench for ff_sweep_sequencer. It includes a small model of the test
// core: address 1 acks after one cycle, address 0 after a shift delay, and
// address 2 after a test delay, returning 100, 200, 300 ... per sweep.
// Table-driven sweeps are followed by hand-written corner sequences.
module tb_ff_sweep_sequencer;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned STRIDE_W = 8;
`ifdef SWEEP_TIMEOUT_EN
  localparam int unsigned TB_TMO = 64;
`else
  localparam int unsigned TB_TMO = 1048576;
`endif

  logic                NATIVE_CLK;
  logic                rst_n;
  logic                cfg_start;
  logic [STEP_W-1:0]   cfg_steps;
  logic [STRIDE_W-1:0] cfg_stride;
  logic                cfg_dir;
  logic                cfg_init;
  logic                abort;
  logic                busy, done, err;
  logic                M_EN, M_WR;
  logic [ADDR_W-1:0]   M_ADDR;
  logic [DATA_W-1:0]   M_WDATA;
  logic [DATA_W-1:0]   M_RDATA;
  logic                M_READY;
  logic                res_valid, res_ready;
  logic [STEP_W-1:0]   res_step;
  logic [DATA_W-1:0]   res_prob;

  ff_sweep_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEP_W(STEP_W),
    .STRIDE_W(STRIDE_W), .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .NATIVE_CLK(NATIVE_CLK), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_steps(cfg_steps), .cfg_stride(cfg_stride), .cfg_dir(cfg_dir),
    .cfg_init(cfg_init), .abort(abort), .busy(busy), .done(done), .err(err),
    .M_EN(M_EN), .M_WR(M_WR), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_RDATA(M_RDATA), .M_READY(M_READY), .res_valid(res_valid),
    .res_ready(res_ready), .res_step(res_step), .res_prob(res_prob)
  );

  initial NATIVE_CLK = 1'b0;
  always #5 NATIVE_CLK = ~NATIVE_CLK;

  // Core model and bus/record monitor (counters are cumulative).
  int   n_en = 0, n_a1 = 0, n_a0 = 0, n_test = 0, n_rec = 0, n_done = 0;
  int   n_wd_bad = 0, n_b2b = 0;
  int   test_base = 0;
  logic exp_init = 1'b0, exp_dir = 1'b0, no_rdy0 = 1'b0;
  logic prev_en = 1'b0;
  logic pend;
  logic [1:0] pend_addr;
  int   cnt;
  logic [STEP_W-1:0] rec_step [0:255];
  logic [DATA_W-1:0] rec_prob [0:255];

  always @(posedge NATIVE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      M_READY   <= 1'b0;
      M_RDATA   <= '0;
      pend      <= 1'b0;
      pend_addr <= 2'd0;
      cnt       <= 0;
    end else begin
      M_READY <= 1'b0;
      prev_en <= M_EN;
      if (M_EN && prev_en) n_b2b <= n_b2b + 1;
      if (done) n_done <= n_done + 1;
      if (res_valid && res_ready) begin
        rec_step[8'(n_rec)] <= res_step;
        rec_prob[8'(n_rec)] <= res_prob;
        n_rec <= n_rec + 1;
      end
      if (M_EN) begin
        n_en <= n_en + 1;
        case (M_ADDR)
          3'd1: begin
            n_a1 <= n_a1 + 1;
            if (M_WDATA != 32'(exp_init) || !M_WR) n_wd_bad <= n_wd_bad + 1;
            M_READY <= 1'b1;
          end
          3'd0: begin
            n_a0 <= n_a0 + 1;
            if (M_WDATA != 32'(exp_dir) || !M_WR) n_wd_bad <= n_wd_bad + 1;
            if (!no_rdy0) begin pend <= 1'b1; pend_addr <= 2'd0; cnt <= 3; end
          end
          3'd2: begin
            n_test <= n_test + 1;
            if (M_WR) n_wd_bad <= n_wd_bad + 1;
            pend <= 1'b1; pend_addr <= 2'd2; cnt <= 4;
          end
          default: n_wd_bad <= n_wd_bad + 1;
        endcase
      end else if (pend) begin
        if (cnt == 1) begin
          M_READY <= 1'b1;
          pend    <= 1'b0;
          if (pend_addr == 2'd2) M_RDATA <= 32'(100 * (n_test - test_base));
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;
  int s_en, s_a1, s_a0, s_t, s_rec, s_done, s_wd, s_b2b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_en = n_en; s_a1 = n_a1; s_a0 = n_a0; s_t = n_test; s_rec = n_rec;
    s_done = n_done; s_wd = n_wd_bad; s_b2b = n_b2b;
    test_base = n_test;
  endtask

  task automatic setup(input int steps, input int stride, input logic dir, input logic init);
    cfg_steps  = STEP_W'(steps);
    cfg_stride = STRIDE_W'(stride);
    cfg_dir    = dir;
    cfg_init   = init;
    exp_dir    = dir;
    exp_init   = init;
  endtask

  task automatic pulse_start();
    @(negedge NATIVE_CLK) cfg_start = 1'b1;
    @(negedge NATIVE_CLK) cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!done && k < lim) begin
      @(negedge NATIVE_CLK);
      k++;
    end
    chk("done_seen", 64'(done), 64'(1));
    @(negedge NATIVE_CLK);
    @(negedge NATIVE_CLK);
  endtask

  typedef struct {
    int   steps;
    int   stride;
    logic dir;
    logic init;
    int   a0;
    int   tests;
  } vec_t;

  vec_t vt [0:4];

  initial begin
    logic [STEP_W-1:0] h_step;
    logic [DATA_W-1:0] h_prob;
    int unstable;
    int k;

    vt[0] = '{steps: 3, stride: 2, dir: 1'b1, init: 1'b1, a0: 4, tests: 3};
    vt[1] = '{steps: 2, stride: 3, dir: 1'b0, init: 1'b0, a0: 3, tests: 2};
    vt[2] = '{steps: 1, stride: 5, dir: 1'b1, init: 1'b0, a0: 0, tests: 1};
    vt[3] = '{steps: 4, stride: 1, dir: 1'b0, init: 1'b1, a0: 3, tests: 4};
    vt[4] = '{steps: 0, stride: 2, dir: 1'b1, init: 1'b1, a0: 0, tests: 0};

    rst_n = 1'b0; cfg_start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    setup(0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge NATIVE_CLK);
    chk("reset_ctl", 64'({busy, done, err}), 64'(0));
    chk("reset_bus", 64'({M_EN, M_WR, M_ADDR, M_WDATA}), 64'(0));
    chk("reset_res", 64'({res_valid, res_step, res_prob}), 64'(0));
    rst_n = 1'b1;
    @(negedge NATIVE_CLK);

    // Reset in the middle of a shift wait abandons the sweep silently.
    snap();
    setup(3, 4, 1'b1, 1'b1);
    pulse_start();
    k = 0;
    while (n_a0 == s_a0 && k < 200) begin @(negedge NATIVE_CLK); k++; end
    chk("mid_shift_reached", 64'(n_a0 - s_a0), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 64'({busy, done, err}), 64'(0));
    chk("async_rst_bus", 64'({M_EN, M_WR, M_ADDR, M_WDATA}), 64'(0));
    chk("async_rst_res", 64'({res_valid, res_step, res_prob}), 64'(0));
    repeat (2) @(negedge NATIVE_CLK);
    rst_n = 1'b1;
    repeat (20) @(negedge NATIVE_CLK);
    chk("rst_no_done", 64'(n_done - s_done), 64'(0));

    // Table-driven sweeps with an always-ready consumer.
    for (int v = 0; v < 5; v++) begin
      snap();
      setup(vt[v].steps, vt[v].stride, vt[v].dir, vt[v].init);
      pulse_start();
      wait_done(3000);
      chk($sformatf("v%0d_addr1", v), 64'(n_a1 - s_a1), 64'((vt[v].steps > 0) ? 1 : 0));
      chk($sformatf("v%0d_addr0", v), 64'(n_a0 - s_a0), 64'(vt[v].a0));
      chk($sformatf("v%0d_tests", v), 64'(n_test - s_t), 64'(vt[v].tests));
      chk($sformatf("v%0d_recs", v), 64'(n_rec - s_rec), 64'(vt[v].tests));
      chk($sformatf("v%0d_dones", v), 64'(n_done - s_done), 64'(1));
      chk($sformatf("v%0d_wdata", v), 64'(n_wd_bad - s_wd), 64'(0));
      chk($sformatf("v%0d_b2b", v), 64'(n_b2b - s_b2b), 64'(0));
      chk($sformatf("v%0d_err", v), 64'(err), 64'(0));
      for (int i = 0; i < vt[v].tests && i < n_rec - s_rec; i++) begin
        chk($sformatf("v%0d_rec%0d_step", v, i), 64'(rec_step[8'(s_rec + i)]), 64'(i));
        chk($sformatf("v%0d_rec%0d_prob", v, i), 64'(rec_prob[8'(s_rec + i)]), 64'(100 * (i + 1)));
      end
    end

    // steps = 0: done two cycles after start, no bus strobes.
    snap();
    setup(0, 1, 1'b1, 1'b1);
    @(negedge NATIVE_CLK) cfg_start = 1'b1;
    @(negedge NATIVE_CLK) cfg_start = 1'b0;
    chk("z_done_c1", 64'(done), 64'(0));
    chk("z_busy_c1", 64'(busy), 64'(1));
    @(negedge NATIVE_CLK);
    chk("z_done_c2", 64'(done), 64'(1));
    chk("z_busy_c2", 64'(busy), 64'(0));
    repeat (3) @(negedge NATIVE_CLK);
    chk("z_no_strobe", 64'(n_en - s_en), 64'(0));
    chk("z_no_rec", 64'(n_rec - s_rec), 64'(0));

    // Start-to-first-strobe latency of two cycles.
    snap();
    setup(1, 0, 1'b0, 1'b0);
    @(negedge NATIVE_CLK) cfg_start = 1'b1;
    @(negedge NATIVE_CLK) cfg_start = 1'b0;
    chk("lat_en_c1", 64'(M_EN), 64'(0));
    chk("lat_busy_c1", 64'(busy), 64'(1));
    @(negedge NATIVE_CLK);
    chk("lat_strobe_c2", 64'({M_EN, M_WR, M_ADDR}), 64'({1'b1, 1'b1, 3'd1}));
    wait_done(500);
    chk("lat_rec_prob", 64'(rec_prob[8'(s_rec)]), 64'(100));

    // Backpressure: stall 50 cycles on the first record, stray start ignored.
    snap();
    setup(4, 0, 1'b1, 1'b0);
    res_ready = 1'b0;
    pulse_start();
    k = 0;
    while (!res_valid && k < 500) begin @(negedge NATIVE_CLK); k++; end
    chk("bp_valid", 64'(res_valid), 64'(1));
    h_step = res_step;
    h_prob = res_prob;
    chk("bp_first_step", 64'(h_step), 64'(0));
    chk("bp_first_prob", 64'(h_prob), 64'(100));
    s_en = n_en;
    unstable = 0;
    for (int c = 0; c < 50; c++) begin
      cfg_start = (c == 10);
      @(negedge NATIVE_CLK);
      if (!res_valid || res_step != h_step || res_prob != h_prob) unstable++;
    end
    cfg_start = 1'b0;
    chk("bp_stable", 64'(unstable), 64'(0));
    chk("bp_no_strobe", 64'(n_en - s_en), 64'(0));
    res_ready = 1'b1;
    wait_done(3000);
    repeat (10) @(negedge NATIVE_CLK);
    chk("bp_recs", 64'(n_rec - s_rec), 64'(4));
    chk("bp_tests", 64'(n_test - s_t), 64'(4));
    chk("bp_dones", 64'(n_done - s_done), 64'(1));
    chk("bp_idle", 64'(busy), 64'(0));
    chk("bp_last_prob", 64'(rec_prob[8'(s_rec + 3)]), 64'(400));

    // Abort while the point-1 test is in flight.
    snap();
    setup(5, 1, 1'b1, 1'b1);
    pulse_start();
    k = 0;
    while (n_test - s_t < 2 && k < 500) begin @(negedge NATIVE_CLK); k++; end
    abort = 1'b1;
    wait_done(500);
    abort = 1'b0;
    chk("ab_recs", 64'(n_rec - s_rec), 64'(2));
    chk("ab_shifts", 64'(n_a0 - s_a0), 64'(1));
    chk("ab_tests", 64'(n_test - s_t), 64'(2));
    chk("ab_rec1_step", 64'(rec_step[8'(s_rec + 1)]), 64'(1));
    chk("ab_rec1_prob", 64'(rec_prob[8'(s_rec + 1)]), 64'(200));

`ifdef SWEEP_TIMEOUT_EN
    begin
      int t_s, t_d;
      t_s = -1000; t_d = 0;
      snap();
      no_rdy0 = 1'b1;
      setup(2, 1, 1'b1, 1'b0);
      pulse_start();
      for (int c = 0; c < 400; c++) begin
        if (M_EN && M_ADDR == 3'd0) t_s = c;
        if (done) begin t_d = c; break; end
        @(negedge NATIVE_CLK);
      end
      chk("tmo_latency", 64'(t_d - t_s), 64'(64));
      chk("tmo_err", 64'(err), 64'(1));
      repeat (2) @(negedge NATIVE_CLK);
      chk("tmo_recs", 64'(n_rec - s_rec), 64'(1));
      no_rdy0 = 1'b0;
      repeat (10) @(negedge NATIVE_CLK);
      setup(1, 0, 1'b0, 1'b0);
      pulse_start();
      chk("tmo_err_clear", 64'(err), 64'(0));
      wait_done(500);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ff_sweep_sequencer.md
Name: ff_sweep_sequencer

Overview:
- Native-bus master that sits directly upstream of the flip-flop metastability test core.
- Automates a phase sweep. It loads the init value once, then for each sweep point it runs one probability test and emits a result record. Between points it issues a configured number of phase-shift steps.
- Results leave on a valid/ready stream toward the host logger or readback FIFO.

Parameters:
- ADDR_W, 3, native address width.
- DATA_W, 32, native data width.
- STEP_W, 16, width of step count and step index.
- STRIDE_W, 8, width of phase-shift steps per sweep point.
- TIMEOUT_CYCLES, 1048576, READY wait limit; used only with SWEEP_TIMEOUT_EN.

Ports:
- NATIVE_CLK  in  1  clock; shared with the test core.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle pulse; starts a sweep; ignored while busy.
- cfg_steps  in  STEP_W  number of sweep points; sampled at start.
- cfg_stride  in  STRIDE_W  phase-shift steps between points; sampled at start.
- cfg_dir  in  1  phase direction; 1 = increment; driven as data bit 0 of each shift write.
- cfg_init  in  1  init value written to core address 1.
- abort  in  1  level; requests early stop.
- busy  out  1  high from the cycle after accepted start until FINISH.
- done  out  1  one-cycle pulse at sweep end.
- err  out  1  sticky timeout flag; cleared at the next start.
- M_EN  out  1  bus strobe.
- M_WR  out  1  1 = write.
- M_ADDR  out  ADDR_W  bus address.
- M_WDATA  out  DATA_W  write data.
- M_RDATA  in  DATA_W  core read data.
- M_READY  in  1  core ready (registered in the core).
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accept.
- res_step  out  STEP_W  sweep point index, starting at 0.
- res_prob  out  DATA_W  probability count for that point.

Behaviour:
- Reset: rst_n is asynchronous and active-low. Every output and register goes to 0, the FSM goes to IDLE, and err is cleared. Reset mid-sweep abandons the sweep with no done pulse.

Bus rules:
- M_ADDR and M_WR are held stable for a whole transaction, from the strobe cycle until the cycle M_READY is seen high.
- M_EN is high for exactly 1 cycle per transaction. The core decodes its phase-shift enable and test start combinationally from M_EN, so a longer strobe causes repeated shifts or tests.
- Between transactions, M_EN is 0 and M_ADDR/M_WR keep their last values.
- A transaction completes in the cycle M_READY is 1, and M_RDATA is captured in that same cycle. M_READY is ignored in the strobe cycle itself.

Transactions per address:
- Address 1 write: M_WDATA = {0, cfg_init}. Ready one cycle after the strobe.
- Address 0 write: M_WDATA = {0, cfg_dir}. Ready follows the phase-shift done signal.
- Address 2 read (M_WR = 0): starts a test. Ready on test completion.

FSM states:
- IDLE: on cfg_start, latch cfg_steps, cfg_stride and cfg_dir, clear step_idx and err. If steps = 0, go to FINISH with no bus activity; otherwise go to LOAD.
- LOAD: strobe address 1, then wait for ready. Go to TEST.
- TEST: strobe address 2 read, then TEST_WAIT. On ready, latch res_prob = M_RDATA and res_step = step_idx, set res_valid, go to PUSH.
- PUSH: hold until res_valid & res_ready.
  - If step_idx = steps-1 or abort is high: go to FINISH.
  - Else: step_idx += 1, load shift_cnt = stride. Go to SHIFT if stride ≠ 0, else TEST.
- SHIFT: strobe address 0, then SHIFT_WAIT. On ready, shift_cnt -= 1. When it reaches 0 go to TEST, else back to SHIFT.
  - Minimum 1 idle cycle between consecutive shift strobes.
- FINISH: done = 1 for one cycle, busy = 0, go to IDLE.

Boundary cases:
- Result payload is stable while res_valid = 1 and res_ready = 0.
- A new point never starts until the previous record is accepted (backpressure stalls the bus).
- abort takes effect only at PUSH or IDLE. An in-flight transaction always completes, because the core FSM cannot be interrupted.
- cfg_start while busy is ignored.
- step_idx never wraps: steps ≤ 2^STEP_W − 1.
- Latency from start to the first address-1 strobe is 2 cycles.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - A counter runs in every *_WAIT state and clears on each strobe.
  - If it reaches TIMEOUT_CYCLES without M_READY, set err and go to FINISH (done pulses, no record emitted).
- Undefined:
  - Waits are unbounded.
  - err is tied to 0 and no counter is synthesised.

Test Plan:
- Steps=3, stride=2, dir=1, init=1; core model returns prob 100, 200, 300 → exactly 1 address-1 write (data 1), 4 address-0 writes (data 1), 3 tests; records (0,100), (1,200), (2,300); one done pulse; M_EN never high for 2 consecutive cycles.
- Steps=0 → done pulse 2 cycles after start; zero M_EN strobes; no record.
- Steps=4, stride=0, res_ready held low for 50 cycles after the first record → no bus strobe during the stall; res_prob and res_step stable; sweep resumes on accept.
- Steps=5; abort raised while the point-1 test is in flight → point-1 record emitted, then done; no further shift strobes; exactly 2 records.
- SWEEP_TIMEOUT_EN with TIMEOUT_CYCLES=64; model never asserts ready on address 0 → err=1 and done 64 cycles after the shift strobe; next start clears err.
- rst_n pulsed low during SHIFT_WAIT → all outputs 0 immediately; no done; a subsequent start runs a clean sweep.
